// File: rtl/bram_readback_pkg.sv
// Shared types and default sizes for the block-RAM readback streamer.
package bram_readback_pkg;

    localparam int unsigned DEFAULT_WID_MEM   = 18;
    localparam int unsigned DEFAULT_DEPTH_MEM = 2048;
    localparam int unsigned DEFAULT_ADDR_W    = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rb_state_t;

    typedef struct packed {
        logic [DEFAULT_WID_MEM-1:0] data;
        logic [DEFAULT_ADDR_W-1:0]  addr;
        logic                       last;
    } rb_beat_t;

endpackage

// File: rtl/rb_beat_fifo.sv
// First-word-fall-through beat FIFO; head, valid and count all come straight from flops.
module rb_beat_fifo
    import bram_readback_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  rb_beat_t         push_beat_i,
    input  logic             pop_i,
    output logic             valid_o,
    output rb_beat_t         head_o,
    output logic [CNT_W-1:0] count_o
);

    rb_beat_t         mem_q [DEPTH];
    rb_beat_t         head_q, head_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             do_pop;

    assign do_pop = pop_i && valid_q;

    // Pointer/count update and look-ahead of the next head entry.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        if (push_i && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
        // When the FIFO is (or becomes) empty the incoming beat is the new head.
        if ((count_q == '0) || ((count_q == CNT_W'(1)) && do_pop)) begin
            head_d = push_beat_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        valid_d = (count_d != '0);
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_beat_i;
        end
    end

    assign valid_o = valid_q;
    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/bram_readback_streamer.sv
// Streams every word of a block RAM out in address order over valid/ready.
// Optional feature macro: CHECKSUM_EN adds a running mod-2^32 sum of transferred words.
module bram_readback_streamer
    import bram_readback_pkg::*;
#(
    parameter int unsigned WID_MEM    = DEFAULT_WID_MEM,
    parameter int unsigned DEPTH_MEM  = DEFAULT_DEPTH_MEM,
    parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  mem_raddr,
    input  logic [WID_MEM-1:0] mem_dout,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WID_MEM-1:0] m_data,
    output logic [ADDR_W-1:0]  m_addr,
    output logic               m_last
`ifdef CHECKSUM_EN
    ,
    output logic [31:0]        checksum,
    output logic               checksum_valid
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

    rb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;
    logic              inflight_q, inflight_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              issue, pop, last_pop;
    logic [OCC_W-1:0]  occupancy;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_valid;
    rb_beat_t          push_beat, head;

    // A read may only be issued if its data is guaranteed a FIFO slot.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q);
    assign issue     = (state_q == READ) && (occupancy < OCC_W'(FIFO_DEPTH));
    assign pop       = fifo_valid && m_ready;
    assign last_pop  = pop && head.last;

    assign push_beat.data = DEFAULT_WID_MEM'(mem_dout);
    assign push_beat.addr = DEFAULT_ADDR_W'(inflight_addr_q);
    assign push_beat.last = (inflight_addr_q == LAST_ADDR);

    // Next-state logic for the FSM, address counter and in-flight tracking.
    always_comb begin
        state_d         = state_q;
        raddr_d         = raddr_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        inflight_d      = issue;
        inflight_addr_d = issue ? raddr_q : inflight_addr_q;
        case (state_q)
            IDLE: begin
                raddr_d = '0;
                if (start) begin
                    state_d = READ;
                    busy_d  = 1'b1;
                end
            end
            READ: begin
                if (issue) begin
                    if (raddr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        raddr_d = raddr_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            raddr_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            raddr_q         <= raddr_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    rb_beat_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_beat_i (push_beat),
        .pop_i       (m_ready),
        .valid_o     (fifo_valid),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_raddr = raddr_q;
    assign m_valid   = fifo_valid;
    assign m_data    = WID_MEM'(head.data);
    assign m_addr    = ADDR_W'(head.addr);
    assign m_last    = head.last;

`ifdef CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    logic        sum_valid_q, sum_valid_d;

    // Running sum of accepted beats, cleared by an accepted start.
    always_comb begin
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;
        if ((state_q == IDLE) && start) begin
            sum_d       = '0;
            sum_valid_d = 1'b0;
        end else if (pop) begin
            sum_d = sum_q + 32'(m_data);
        end
        if (done_d) begin
            sum_valid_d = 1'b1;
        end
    end

    // Checksum registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign checksum       = sum_q;
    assign checksum_valid = sum_valid_q;
`endif

endmodule

// File: tb/tb_bram_readback_streamer.sv
// Directed bench for bram_readback_streamer with a read-first memory model.
module tb_bram_readback_streamer;

    localparam int NW = 2048;
    localparam int AW = 11;
    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_addr;
    logic          m_last;
`ifdef CHECKSUM_EN
    logic [31:0]   checksum;
    logic          checksum_valid;
`endif

    logic [DW-1:0] mem [NW];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Registered read port, one cycle latency.
    always_ff @(posedge clk) mem_dout <= mem[mem_raddr];

    bram_readback_streamer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .mem_raddr      (mem_raddr),
        .mem_dout       (mem_dout),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_addr         (m_addr),
        .m_last         (m_last)
`ifdef CHECKSUM_EN
        ,
        .checksum       (checksum),
        .checksum_valid (checksum_valid)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // rmode: 0 = always ready, 1 = random ready, 2 = 100-cycle stall after beat 10
    task automatic run_readback(input int rmode, input int restart_at, input int reset_at,
                                input bit fill_ones);
        int            idx = 0;
        int            cyc;
        int            t_first = -1;
        int            t_last = -1;
        int            t_done = -1;
        int            dones = 0;
        int            stall_left = 0;
        bit            stall_used = 0;
        bit            restarted = 0;
        bit            rst_fired = 0;
        bit            finished = 0;
        bit            stalled_prev = 0;
        logic [DW-1:0] hold_d = '0;
        logic [AW-1:0] hold_a = '0;
        logic          hold_l = 1'b0;

        for (int i = 0; i < NW; i++) mem[AW'(i)] = fill_ones ? DW'(18'h3FFFF) : DW'(i);
        @(posedge clk); #1;
        start   = 1'b1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        cyc = 1;
        check("busy_after_start", 32'(busy), 32'd1);
        check("raddr_after_start", 32'(mem_raddr), 32'd0);
`ifdef CHECKSUM_EN
        check("checksum_cleared", checksum, 32'd0);
        check("checksum_valid_cleared", 32'(checksum_valid), 32'd0);
`endif
        while (!finished && cyc < 12000) begin
            if (rst_fired) begin
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                check("reset_m_valid", 32'(m_valid), 32'd0);
                check("reset_busy", 32'(busy), 32'd0);
                check("reset_raddr", 32'(mem_raddr), 32'd0);
                finished = 1;
            end else begin
                if (stalled_prev) begin
                    check("stall_valid", 32'(m_valid), 32'd1);
                    check("stall_data", 32'(m_data), 32'(hold_d));
                    check("stall_addr", 32'(m_addr), 32'(hold_a));
                    check("stall_last", 32'(m_last), 32'(hold_l));
                end
                if (m_valid && t_first < 0) begin
                    t_first = cyc;
                    check("first_beat_latency", 32'(cyc), 32'd3);
                end
                if (m_valid && m_ready) begin
                    check("beat_addr", 32'(m_addr), 32'(idx));
                    check("beat_data", 32'(m_data), 32'(mem[AW'(idx)]));
                    check("beat_last", 32'(m_last), 32'(idx == NW - 1));
                    if (rmode == 0) check("no_bubble", 32'(cyc), 32'(t_first + idx));
                    if (m_last) t_last = cyc;
                    idx++;
                end
                if (rmode == 2 && !m_ready && (stall_left == 50 || stall_left == 0))
                    check("stall_raddr_hold", 32'(mem_raddr), 32'd15);
                stalled_prev = m_valid && !m_ready;
                hold_d = m_data;
                hold_a = m_addr;
                hold_l = m_last;
                if (done) begin
                    dones++;
                    if (dones == 1) begin
                        t_done = cyc;
                        check("done_after_last", 32'(cyc), 32'(t_last + 1));
                        check("beat_count", 32'(idx), 32'(NW));
`ifdef CHECKSUM_EN
                        check("checksum", checksum, fill_ones ? 32'h1FFFF800 : 32'h001FFC00);
                        check("checksum_valid", 32'(checksum_valid), 32'd1);
`endif
                    end
                end
                if (t_done >= 0 && cyc == t_done + 1) begin
                    check("done_pulse_width", 32'(done), 32'd0);
                    check("busy_after_done", 32'(busy), 32'd0);
                    check("done_count", 32'(dones), 32'd1);
                    finished = 1;
                end
            end
            if (!finished) begin
                @(posedge clk); #1;
                cyc++;
                start = 1'b0;
                if (restart_at >= 0 && idx == restart_at && !restarted) begin
                    start     = 1'b1;
                    restarted = 1;
                end
                if (reset_at >= 0 && idx == reset_at && !rst_fired) begin
                    reset     = 1'b1;
                    rst_fired = 1;
                end
                if (rmode == 2 && idx == 11 && !stall_used) begin
                    stall_used = 1;
                    stall_left = 100;
                end
                if (stall_left > 0) begin
                    m_ready = 1'b0;
                    stall_left--;
                end else if (rmode == 1) begin
                    m_ready = 1'($urandom_range(0, 1));
                end else begin
                    m_ready = 1'b1;
                end
                @(negedge clk);
            end
        end
        if (!finished) check("readback_timeout", 32'd0, 32'd1);
        if (rst_fired) begin
            repeat (5) begin
                @(negedge clk);
                check("post_reset_quiet", 32'({m_valid, done, busy}), 32'd0);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < NW; i++) mem[AW'(i)] = DW'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy_init", 32'(busy), 32'd0);
        check("reset_done_init", 32'(done), 32'd0);
        check("reset_valid_init", 32'(m_valid), 32'd0);
        check("reset_raddr_init", 32'(mem_raddr), 32'd0);
`ifdef CHECKSUM_EN
        check("reset_checksum_valid", 32'(checksum_valid), 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        run_readback(0, -1, -1, 1'b0);
        run_readback(1, 500, -1, 1'b0);
        run_readback(2, -1, -1, 1'b0);
        run_readback(0, -1, 1000, 1'b0);
        run_readback(0, -1, -1, 1'b0);
`ifdef CHECKSUM_EN
        run_readback(0, -1, -1, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
